// File: rtl/priority_dec.sv
// Registered 2-to-4 priority decoder: takes an encoded index through valid/ready,
// drives the one-hot line for HOLD_CYCLES cycles, then idles for GAP_CYCLES cycles.
`timescale 1ns/1ps
module priority_dec #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] Y,
  input  logic       valid,
  output logic       ready,
  output logic [3:0] D,
  output logic       busy,
  output logic       done,
  output logic [7:0] accept_cnt
);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [3:0] d_reg, d_next;
  logic [7:0] acc_reg, acc_next;
  logic [3:0] dec;
  logic       accept;

  // Y=00 selects the highest-priority line D[3], Y=11 the lowest D[0].
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dec
      assign dec[gi] = (Y == 2'(3 - gi));
    end
  endgenerate

  assign ready      = (state_reg == IDLE) && !rst;
  assign accept     = valid && ready;
  assign busy       = (state_reg != IDLE);
  assign done       = (state_reg == DRIVE) && (cnt_reg == 8'd0);
  assign D          = d_reg;
  assign accept_cnt = acc_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    d_next     = d_reg;
    acc_next   = acc_reg;
    if (accept && (acc_reg != 8'hFF)) begin
      acc_next = acc_reg + 8'd1;
    end
    case (state_reg)
      IDLE: begin
        d_next = 4'b0000;
        if (accept) begin
          state_next = DRIVE;
          d_next     = dec;
          cnt_next   = HOLD_LOAD;
        end
      end
      DRIVE: begin
        if (cnt_reg == 8'd0) begin
          d_next = 4'b0000;
          if (GAP_CYCLES > 0) begin
            state_next = GAP;
            cnt_next   = GAP_LOAD;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      GAP: begin
        d_next = 4'b0000;
        if (cnt_reg == 8'd0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        d_next     = 4'b0000;
        cnt_next   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
      d_reg     <= 4'b0000;
      acc_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      d_reg     <= d_next;
      acc_reg   <= acc_next;
    end
  end

endmodule

// File: tb/tb_priority_dec.sv
// Self-checking bench for priority_dec: two instances (HOLD=4/GAP=0 and HOLD=1/GAP=2),
// expected one-hot codes queued at each accept and compared as bursts appear.
`timescale 1ns/1ps
module tb_priority_dec;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, valid_a = 1'b0;
  logic [1:0] y_a = 2'd0;
  logic       ready_a, busy_a, done_a;
  logic [3:0] d_a;
  logic [7:0] cnt_a;

  logic       rst_b = 1'b1, valid_b = 1'b0;
  logic [1:0] y_b = 2'd0;
  logic       ready_b, busy_b, done_b;
  logic [3:0] d_b;
  logic [7:0] cnt_b;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];

  priority_dec #(.HOLD_CYCLES(4), .GAP_CYCLES(0)) u_dut_a (
    .clk(clk), .rst(rst_a), .Y(y_a), .valid(valid_a), .ready(ready_a),
    .D(d_a), .busy(busy_a), .done(done_a), .accept_cnt(cnt_a)
  );

  priority_dec #(.HOLD_CYCLES(1), .GAP_CYCLES(2)) u_dut_b (
    .clk(clk), .rst(rst_b), .Y(y_b), .valid(valid_b), .ready(ready_b),
    .D(d_b), .busy(busy_b), .done(done_b), .accept_cnt(cnt_b)
  );

  function automatic logic [3:0] onehot_of(input logic [1:0] y);
    logic [3:0] top;
    top = 4'b1000;
    return top >> y;
  endfunction

  // D must be zero or one-hot, and done only ever accompanies a driven line.
  always @(negedge clk) begin
    checks++;
    if (!$onehot0(d_a) || (done_a && d_a == 4'b0000)) begin
      errors++;
      $display("FAIL inv_a d=%b done=%b required one-hot-or-zero with done only while driving", d_a, done_a);
    end
    checks++;
    if (!$onehot0(d_b) || (done_b && d_b == 4'b0000)) begin
      errors++;
      $display("FAIL inv_b d=%b done=%b required one-hot-or-zero with done only while driving", d_b, done_b);
    end
  end

  task automatic test_reset;
    rst_a = 1'b1; rst_b = 1'b1;
    valid_a = 1'b1; y_a = 2'd0;
    valid_b = 1'b1; y_b = 2'd0;
    repeat (2) @(negedge clk);
    checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", ready_a); end
    checks++; if (d_a !== 4'b0000) begin errors++; $display("FAIL rst_d got=%b exp=0000", d_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done_a); end
    checks++; if (cnt_a !== 8'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", cnt_a); end
    checks++; if (cnt_b !== 8'd0) begin errors++; $display("FAIL rst_cnt_b got=%0d exp=0", cnt_b); end
    rst_a = 1'b0; rst_b = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0;
    #1;
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b exp=1", ready_a); end
    checks++; if (ready_b !== 1'b1) begin errors++; $display("FAIL rst_release_ready_b got=%b exp=1", ready_b); end
    @(negedge clk);
    checks++; if (cnt_a !== 8'd0) begin errors++; $display("FAIL rst_no_accept got=%0d exp=0", cnt_a); end
    checks++; if (d_a !== 4'b0000) begin errors++; $display("FAIL rst_idle_d got=%b exp=0000", d_a); end
  endtask

  task automatic test_single;
    y_a = 2'd0; valid_a = 1'b1;
    #1;
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", ready_a); end
    exp_q.push_back(onehot_of(2'd0));
    @(negedge clk);
    valid_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      checks++; if (d_a !== exp_q[0]) begin errors++; $display("FAIL single_d cyc=%0d got=%b exp=%b", i, d_a, exp_q[0]); end
      checks++; if (done_a !== (i == 3)) begin errors++; $display("FAIL single_done cyc=%0d got=%b exp=%b", i, done_a, (i == 3)); end
      checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL single_ready_drive cyc=%0d got=%b exp=0", i, ready_a); end
      checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL single_busy cyc=%0d got=%b exp=1", i, busy_a); end
    end
    void'(exp_q.pop_front());
    @(negedge clk);
    checks++; if (d_a !== 4'b0000) begin errors++; $display("FAIL single_after_d got=%b exp=0000", d_a); end
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL single_after_ready got=%b exp=1", ready_a); end
    checks++; if (cnt_a !== 8'd1) begin errors++; $display("FAIL single_cnt got=%0d exp=1", cnt_a); end
    $display("single: Y=00 -> %b burst, accept_cnt=%0d", 4'b1000, cnt_a);
  endtask

  task automatic test_sweep;
    logic [1:0] codes [3];
    int idx, bursts, hold, zero_run;
    bit advance;
    codes = '{2'd1, 2'd2, 2'd3};
    idx = 0; bursts = 0; hold = 0; zero_run = 0; advance = 1'b0;
    valid_a = 1'b1; y_a = codes[0];
    if (ready_a) begin exp_q.push_back(onehot_of(y_a)); idx = 1; advance = 1'b1; end
    for (int cyc = 0; cyc < 40 && bursts < 3; cyc++) begin
      @(negedge clk);
      if (advance) begin
        advance = 1'b0;
        if (idx < 3) y_a = codes[idx]; else valid_a = 1'b0;
      end
      if (d_a !== 4'b0000) begin
        if (hold == 0 && bursts > 0) begin
          checks++; if (zero_run != 1) begin errors++; $display("FAIL sweep_gap burst=%0d got=%0d exp=1", bursts, zero_run); end
        end
        hold++; zero_run = 0;
        checks++; if (d_a !== exp_q[0]) begin errors++; $display("FAIL sweep_d burst=%0d got=%b exp=%b", bursts, d_a, exp_q[0]); end
        checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL sweep_ready got=%b exp=0", ready_a); end
        if (done_a) begin
          checks++; if (hold != 4) begin errors++; $display("FAIL sweep_hold burst=%0d got=%0d exp=4", bursts, hold); end
          $display("sweep: burst %0d D=%b held %0d cycles", bursts, d_a, hold);
          void'(exp_q.pop_front());
          hold = 0; bursts++;
        end
      end else begin
        zero_run++;
      end
      if (ready_a && valid_a) begin
        exp_q.push_back(onehot_of(y_a)); idx++; advance = 1'b1;
      end
    end
    checks++; if (bursts != 3) begin errors++; $display("FAIL sweep_timeout got=%0d exp=3 bursts", bursts); end
    valid_a = 1'b0;
    @(negedge clk);
    checks++; if (d_a !== 4'b0000) begin errors++; $display("FAIL sweep_end_d got=%b exp=0000", d_a); end
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL sweep_end_ready got=%b exp=1", ready_a); end
    checks++; if (cnt_a !== 8'd4) begin errors++; $display("FAIL sweep_cnt got=%0d exp=4", cnt_a); end
  endtask

  task automatic test_hold1_gap2;
    y_b = 2'd3; valid_b = 1'b1;
    #1;
    checks++; if (ready_b !== 1'b1) begin errors++; $display("FAIL gap_ready0 got=%b exp=1", ready_b); end
    exp_q.push_back(onehot_of(2'd3));
    @(negedge clk);
    valid_b = 1'b0;
    checks++; if (d_b !== exp_q[0]) begin errors++; $display("FAIL gap_d got=%b exp=%b", d_b, exp_q[0]); end
    checks++; if (done_b !== 1'b1) begin errors++; $display("FAIL gap_done got=%b exp=1", done_b); end
    checks++; if (ready_b !== 1'b0) begin errors++; $display("FAIL gap_ready_drive got=%b exp=0", ready_b); end
    void'(exp_q.pop_front());
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (d_b !== 4'b0000) begin errors++; $display("FAIL gap_idle_d cyc=%0d got=%b exp=0000", i, d_b); end
      checks++; if (ready_b !== 1'b0) begin errors++; $display("FAIL gap_idle_ready cyc=%0d got=%b exp=0", i, ready_b); end
      checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL gap_idle_busy cyc=%0d got=%b exp=1", i, busy_b); end
      checks++; if (done_b !== 1'b0) begin errors++; $display("FAIL gap_idle_done cyc=%0d got=%b exp=0", i, done_b); end
    end
    @(negedge clk);
    checks++; if (ready_b !== 1'b1) begin errors++; $display("FAIL gap_end_ready got=%b exp=1", ready_b); end
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL gap_end_busy got=%b exp=0", busy_b); end
    checks++; if (cnt_b !== 8'd1) begin errors++; $display("FAIL gap_cnt got=%0d exp=1", cnt_b); end
    $display("hold1_gap2: Y=11 -> D=0001 one cycle, 2 gap cycles");
  endtask

  task automatic test_ignore;
    y_a = 2'd0; valid_a = 1'b1;
    exp_q.push_back(onehot_of(2'd0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (d_a !== exp_q[0]) begin errors++; $display("FAIL ignore_d cyc=%0d got=%b exp=%b", i, d_a, exp_q[0]); end
      checks++; if (done_a !== (i == 3)) begin errors++; $display("FAIL ignore_done cyc=%0d got=%b exp=%b", i, done_a, (i == 3)); end
      y_a = 2'd3;
      valid_a = (i % 2) == 1;
    end
    void'(exp_q.pop_front());
    @(negedge clk);
    valid_a = 1'b0;
    checks++; if (d_a !== 4'b0000) begin errors++; $display("FAIL ignore_end_d got=%b exp=0000", d_a); end
    checks++; if (cnt_a !== 8'd5) begin errors++; $display("FAIL ignore_cnt got=%0d exp=5", cnt_a); end
    $display("ignore: Y/valid churn during burst, accept_cnt=%0d", cnt_a);
  endtask

  task automatic test_reset_mid;
    y_a = 2'd2; valid_a = 1'b1;
    exp_q.push_back(onehot_of(2'd2));
    @(negedge clk);
    valid_a = 1'b0;
    checks++; if (d_a !== exp_q[0]) begin errors++; $display("FAIL midrst_d got=%b exp=%b", d_a, exp_q[0]); end
    void'(exp_q.pop_front());
    @(negedge clk);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL midrst_busy got=%b exp=1", busy_a); end
    rst_a = 1'b1; valid_a = 1'b1; y_a = 2'd1;
    @(negedge clk);
    checks++; if (d_a !== 4'b0000) begin errors++; $display("FAIL midrst_d0 got=%b exp=0000", d_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL midrst_busy0 got=%b exp=0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", done_a); end
    checks++; if (cnt_a !== 8'd0) begin errors++; $display("FAIL midrst_cnt got=%0d exp=0", cnt_a); end
    checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL midrst_ready_gated got=%b exp=0", ready_a); end
    rst_a = 1'b0; valid_a = 1'b0;
    #1;
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", ready_a); end
    @(negedge clk);
    checks++; if (cnt_a !== 8'd0) begin errors++; $display("FAIL midrst_cnt_after got=%0d exp=0", cnt_a); end
    checks++; if (d_a !== 4'b0000) begin errors++; $display("FAIL midrst_d_after got=%b exp=0000", d_a); end
    $display("reset_mid: burst aborted, accept_cnt=%0d", cnt_a);
  endtask

  task automatic test_back_to_back;
    int accepts;
    bit advance;
    accepts = 0; advance = 1'b0;
    valid_a = 1'b1; y_a = 2'($urandom_range(0, 3));
    if (ready_a) begin exp_q.push_back(onehot_of(y_a)); accepts = 1; advance = 1'b1; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (accepts == 300 && !valid_a && exp_q.size() == 0) break;
      @(negedge clk);
      if (advance) begin
        advance = 1'b0;
        if (accepts < 300) y_a = 2'($urandom_range(0, 3)); else valid_a = 1'b0;
      end
      if (d_a !== 4'b0000) begin
        checks++; if (d_a !== exp_q[0]) begin errors++; $display("FAIL b2b_d acc=%0d got=%b exp=%b", accepts, d_a, exp_q[0]); end
        if (done_a && exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (ready_a && valid_a) begin
        checks++;
        if (cnt_a !== 8'((accepts > 255) ? 255 : accepts)) begin
          errors++; $display("FAIL b2b_cnt acc=%0d got=%0d exp=%0d", accepts, cnt_a, (accepts > 255) ? 255 : accepts);
        end
        exp_q.push_back(onehot_of(y_a)); accepts++; advance = 1'b1;
      end
    end
    checks++; if (accepts != 300 || exp_q.size() != 0) begin errors++; $display("FAIL b2b_timeout got=%0d accepts exp=300 (pending=%0d)", accepts, exp_q.size()); end
    @(negedge clk);
    checks++; if (cnt_a !== 8'd255) begin errors++; $display("FAIL b2b_saturate got=%0d exp=255", cnt_a); end
    $display("back_to_back: %0d accepts, accept_cnt=%0d", accepts, cnt_a);
  endtask

  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_hold1_gap2();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
